// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: assembles 32-bit little-endian instructions from four byte reads.
// Optional direct-mapped instruction cache is enabled by defining ICACHE_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  stall_signal,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_stall
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [1:0]  byte_cnt;
    logic [23:0] inst_buf;
    logic        accept, last_byte, hit;
    logic [31:0] hit_inst;

    assign accept    = if_valid && !stall_signal[1];
    assign last_byte = (state == FETCH) && mem_valid && (byte_cnt == 2'd3);

    logic unused_bits;
    assign unused_bits = ^{stall_signal[4:2], stall_signal[0], br_target[1:0]};

`ifdef ICACHE_EN
    localparam int IDX = $clog2(ICACHE_LINES);
    localparam int TW  = 30 - IDX;

    logic [ICACHE_LINES-1:0] line_vld;
    logic [TW-1:0]           tag_mem  [ICACHE_LINES];
    logic [31:0]             data_mem [ICACHE_LINES];
    logic [IDX-1:0]          idx;
    logic [TW-1:0]           tag;
    logic                    fill;

    assign idx      = pc[IDX+1:2];
    assign tag      = pc[31:IDX+2];
    assign hit      = line_vld[idx] && (tag_mem[idx] == tag);
    assign hit_inst = data_mem[idx];
    // A redirect on the completing edge aborts the fill
    assign fill     = last_byte && !br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    line_vld <= '0;
        else if (fill) line_vld[idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= {mem_data, inst_buf};
        end
    end
`else
    logic [31:0] unused_lines;
    assign unused_lines = ICACHE_LINES;
    assign hit      = 1'b0;
    assign hit_inst = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (br_taken) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = hit ? DONE : FETCH;
                FETCH:   if (last_byte) state_nxt = DONE;
                DONE:    if (accept) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stall is held low while in reset so every output reads zero
    always_comb begin
        if_stall = rst_n && (state != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            byte_cnt <= 2'd0;
            inst_buf <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            if_pc    <= '0;
            if_inst  <= '0;
            if_valid <= 1'b0;
        end else if (br_taken) begin
            pc       <= {br_target[31:2], 2'b00};
            byte_cnt <= 2'd0;
            mem_req  <= 1'b0;
            if_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    byte_cnt <= 2'd0;
                    if (hit) begin
                        if_pc    <= pc;
                        if_inst  <= hit_inst;
                        if_valid <= 1'b1;
                    end else begin
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_valid) begin
                        if (byte_cnt == 2'd3) begin
                            mem_req  <= 1'b0;
                            if_pc    <= pc;
                            if_inst  <= {mem_data, inst_buf};
                            if_valid <= 1'b1;
                        end else begin
                            // Shift right so byte 0 ends up in the low lane
                            inst_buf <= {mem_data, inst_buf[23:8]};
                            byte_cnt <= byte_cnt + 2'd1;
                            mem_addr <= mem_addr + 32'd1;
                        end
                    end
                end
                DONE: begin
                    if (accept) begin
                        pc       <= pc + 32'd4;
                        if_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized checks of if_fetch_unit against a transaction-level model:
// the instruction at pc is the little-endian word of a bench-owned byte memory.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  stall_signal;
    logic        br_taken;
    logic [31:0] br_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic [31:0] if_pc, if_inst;
    logic        if_valid, if_stall;

    int checks = 0;
    int failures = 0;
    logic [7:0] mem [1024];
    logic resp_rand = 1'b0;

    if_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_signal(stall_signal),
        .br_taken(br_taken), .br_target(br_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_stall(if_stall)
    );

    always #5 clk = ~clk;

    // Byte memory: responds every cycle, or with random gaps once resp_rand is set
    always @(negedge clk) begin
        if (mem_req && (!resp_rand || $urandom_range(0, 2) != 0)) begin
            mem_valid = 1'b1;
            mem_data  = mem[mem_addr[9:0]];
        end else begin
            mem_valid = 1'b0;
            mem_data  = 8'($urandom);
        end
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 80) begin
            tick();
            n++;
        end
        chk(tag, 32'(if_valid), 32'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_addr"}, mem_addr, addr);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   32'(mem_req),  32'd0);
        chk({tag, "_addr"},  mem_addr,      32'd0);
        chk({tag, "_pc"},    if_pc,         32'd0);
        chk({tag, "_inst"},  if_inst,       32'd0);
        chk({tag, "_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_stall"}, 32'(if_stall), 32'd0);
    endtask

    initial begin
        logic [31:0] model_pc;
        int n, n_acc;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
        rst_n = 1'b0; stall_signal = 5'd0; br_taken = 1'b0; br_target = 32'd0;

        #12 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_mid_fetch");
        @(negedge clk) begin rst_n = 1'b1; stall_signal = 5'b11011; end
        n = 0;
        do begin tick(); n++; end while (!mem_req && n < 2);
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", mem_addr, 32'd0);

        wait_valid("first_valid");
        chk("first_inst", if_inst, 32'h0050_0013);
        chk("first_pc", if_pc, 32'd0);
        chk("first_stall", 32'(if_stall), 32'd0);

        // Frozen latch holds the instruction and leaves memory idle
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_inst", if_inst, 32'h0050_0013);
            chk("hold_pc", if_pc, 32'd0);
            chk("hold_req", 32'(mem_req), 32'd0);
        end
        stall_signal = 5'd0;
        tick();
        wait_req("advance", 32'h4);
        wait_valid("pc4_valid");
        chk("pc4_pc", if_pc, 32'h4);
        chk("pc4_inst", if_inst, word(32'h4));

        // Jump back to 0 while the pc 4 instruction is offered
        br_taken = 1'b1; br_target = 32'h0;
        tick();
        br_taken = 1'b0;
        chk("jmp0_valid", 32'(if_valid), 32'd0);
        chk("jmp0_req", 32'(mem_req), 32'd0);
`ifdef ICACHE_EN
        tick();
        chk("hit_valid", 32'(if_valid), 32'd1);
        chk("hit_req", 32'(mem_req), 32'd0);
`else
        wait_valid("jmp0_fill");
`endif
        chk("jmp0_pc", if_pc, 32'd0);
        chk("jmp0_inst", if_inst, 32'h0050_0013);
        tick();
        wait_valid("pc4b_valid");
        chk("pc4b_pc", if_pc, 32'h4);
        tick();

        // Redirect after two bytes of the pc 8 fetch, with a byte arriving on the same edge
        n = 0;
        while (!(mem_req && mem_addr == 32'hA) && n < 20) begin tick(); n++; end
        chk("mid_fetch_addr", mem_addr, 32'hA);
        br_taken = 1'b1; br_target = 32'h100;
        tick();
        br_taken = 1'b0;
        chk("br_valid", 32'(if_valid), 32'd0);
        chk("br_req", 32'(mem_req), 32'd0);
        wait_req("br", 32'h100);
        wait_valid("br_fill");
        chk("br_pc", if_pc, 32'h100);
        chk("br_inst", if_inst, word(32'h100));

        // Redirect and accept on one edge; low target bits are ignored
        br_taken = 1'b1; br_target = 32'h203;
        tick();
        br_taken = 1'b0;
        wait_req("br_acc", 32'h200);
        wait_valid("br_acc_fill");
        chk("br_acc_pc", if_pc, 32'h200);
        chk("br_acc_inst", if_inst, word(32'h200));

        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        tick();
        br_taken = 1'b0;
        wait_valid("top_fill");
        chk("top_pc", if_pc, 32'hFFFF_FFFC);
        chk("top_inst", if_inst, word(32'hFFFF_FFFC));
        tick();
        wait_req("wrap", 32'h0);

        // Randomized phase against the transaction model
        #1 resp_rand = 1'b1;
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h0; model_pc = 32'h0; n_acc = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            br_taken = 1'b0;
            chk("rnd_stall", 32'(if_stall), 32'(!if_valid));
            if (if_valid) begin
                chk("rnd_pc", if_pc, model_pc);
                chk("rnd_inst", if_inst, word(model_pc));
            end
            stall_signal = 5'($urandom);
            stall_signal[1] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 24) == 0) begin
                br_taken  = 1'b1;
                br_target = $urandom_range(0, 1023);
                model_pc  = {br_target[31:2], 2'b00};
            end else if (if_valid && !stall_signal[1]) begin
                model_pc = model_pc + 32'd4;
                n_acc++;
            end
        end
        chk("rnd_progress", 32'(n_acc > 15), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
